// File: rtl/axi_ctl_target.sv
// AXI4-Lite control target: eight-register file with CTL_STATE start pulse and
// a programmable-length active window for downstream logic.
module axi_ctl_target #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE       = 32'hC0DE_0001,
    parameter int unsigned LED_WIDTH      = 4
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [2:0]                  S_AXI_AWPROT,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [2:0]                  S_AXI_ARPROT,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [31:0]                 ctl_state,
    output logic                        ctl_start,
    output logic                        ctl_active,
    output logic [LED_WIDTH-1:0]        led
);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    logic        aw_held_q, aw_held_d;
    logic [2:0]  aw_idx_q, aw_idx_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] led_q, led_d;
    logic [31:0] ctl_state_q, ctl_state_d;
    logic [31:0] pulse_len_q, pulse_len_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ctl_start_q, ctl_start_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic unused_sigs;
    assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[AXI_ADDR_WIDTH-1:5], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[AXI_ADDR_WIDTH-1:5], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ctl_state     = ctl_state_q;
    assign ctl_start     = ctl_start_q;
    assign ctl_active    = (cnt_q != 32'd0);
    assign led           = led_q[LED_WIDTH-1:0];

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel handshaking this cycle is used directly so commit lands on the next edge.
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    always_comb begin
        aw_held_d   = aw_held_q;
        aw_idx_d    = aw_idx_q;
        w_held_d    = w_held_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        scratch_d   = scratch_q;
        wr_count_d  = wr_count_q;
        led_d       = led_q;
        ctl_state_d = ctl_state_q;
        pulse_len_d = pulse_len_q;
        ctl_start_d = 1'b0;
        cnt_d       = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_idx == 3'd7) ? RespSlverr : RespOkay;
            if (wr_idx != 3'd7) wr_count_d = wr_count_q + 32'd1;
            case (wr_idx)
                3'd1: scratch_d = merge(scratch_q, wr_data, wr_strb);
                3'd3: led_d = merge(led_q, wr_data, wr_strb);
                3'd5: begin
                    ctl_state_d = merge(ctl_state_q, wr_data, wr_strb);
                    ctl_start_d = 1'b1;
                    cnt_d       = pulse_len_q;
                end
                3'd6: pulse_len_d = merge(pulse_len_q, wr_data, wr_strb);
                default: ;
            endcase
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
            if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        end
    end

    // Read mux samples pre-commit state, so a same-cycle write is not visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RespOkay;
            case (S_AXI_ARADDR[4:2])
                3'd0: rdata_d = ID_VALUE;
                3'd1: rdata_d = scratch_q;
                3'd2: rdata_d = wr_count_q;
                3'd3: rdata_d = led_q;
                3'd4: rdata_d = {31'd0, ctl_active};
                3'd5: rdata_d = ctl_state_q;
                3'd6: rdata_d = pulse_len_q;
                default: begin
                    rdata_d = 32'd0;
                    rresp_d = RespSlverr;
                end
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_q   <= 1'b0;
            aw_idx_q    <= 3'd0;
            w_held_q    <= 1'b0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= RespOkay;
            scratch_q   <= 32'd0;
            wr_count_q  <= 32'd0;
            led_q       <= 32'd0;
            ctl_state_q <= 32'd0;
            pulse_len_q <= 32'd16;
            cnt_q       <= 32'd0;
            ctl_start_q <= 1'b0;
        end else begin
            aw_held_q   <= aw_held_d;
            aw_idx_q    <= aw_idx_d;
            w_held_q    <= w_held_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            scratch_q   <= scratch_d;
            wr_count_q  <= wr_count_d;
            led_q       <= led_d;
            ctl_state_q <= ctl_state_d;
            pulse_len_q <= pulse_len_d;
            cnt_q       <= cnt_d;
            ctl_start_q <= ctl_start_d;
        end
    end
endmodule

// File: tb/tb_axi_ctl_target.sv
// Scoreboard bench for axi_ctl_target: directed AXI-Lite traffic, expected
// responses queued at issue time and checked by an independent monitor.
module tb_axi_ctl_target;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata, ctl_state;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, ctl_start, ctl_active;
    logic [3:0]  wstrb, led;
    logic [1:0]  bresp, rresp;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      exp_r[$];
    logic [1:0] exp_b[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    axi_ctl_target dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_AWPROT(3'b000),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_ARPROT(3'b000),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .ctl_state(ctl_state), .ctl_start(ctl_start), .ctl_active(ctl_active), .led(led)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: ready never seen within bound", name);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b.size() == 0) timeout_fail("unexpected_bresp");
            else chk("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                timeout_fail("unexpected_rdata");
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                chk("rdata", rdata, e.data);
                chk("rresp", {30'd0, rresp}, {30'd0, e.resp});
            end
        end
    end

    // All send tasks are entered just after a rising edge.
    task automatic send_aw(input logic [31:0] a);
        bit ok = 0;
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("w_handshake");
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] resp);
        exp_b.push_back(resp);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        rexp_t e;
        e.data = d; e.resp = resp;
        exp_r.push_back(e);
        send_ar(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, starts, rises;
        logic prev;
        rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd1);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_active", {31'd0, ctl_active}, 32'd0);
        chk("rst_ctl_state", ctl_state, 32'd0);
        @(posedge clk); #1;

        rd(32'h1000, 32'hC0DE_0001, 2'b00);
        rd(32'h1018, 32'd16, 2'b00);
        rd(32'h1010, 32'd0, 2'b00);

        // CTL_STATE write with AW and W together; window counted from commit cycle.
        wr(32'h1014, 32'h42, 4'hF, 2'b00);
        chk("ctl_state", ctl_state, 32'h42);
        hi = 0; starts = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ctl_active) hi++;
            if (ctl_start) starts++;
        end
        chk("active_len16", hi, 16);
        chk("start_pulses", starts, 1);
        @(posedge clk); #1;
        rd(32'h1008, 32'd1, 2'b00);

        // Byte strobes with W leading AW by two cycles.
        wr(32'h1004, 32'h1122_3344, 4'hF, 2'b00);
        exp_b.push_back(2'b00);
        send_w(32'hAABB_CCDD, 4'b0101);
        repeat (2) @(posedge clk);
        #1 send_aw(32'h1004);
        rd(32'h1004, 32'h11BB_33DD, 2'b00);

        // Back-pressure on B.
        bready = 1'b0;
        wr(32'h100C, 32'h5, 4'hF, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("bresp_hold", {30'd0, bresp}, 32'd0);
            chk("awready_stall", {31'd0, awready}, 32'd0);
            chk("wready_stall", {31'd0, wready}, 32'd0);
        end
        @(posedge clk); #1 bready = 1'b1;
        chk("led", {28'd0, led}, 32'd5);

        // Back-pressure on R.
        rready = 1'b0;
        rd(32'h1004, 32'h11BB_33DD, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata_hold", rdata, 32'h11BB_33DD);
            chk("arready_stall", {31'd0, arready}, 32'd0);
        end
        @(posedge clk); #1 rready = 1'b1;

        // Reserved index.
        wr(32'h101C, 32'hDEAD_BEEF, 4'hF, 2'b10);
        rd(32'h101C, 32'd0, 2'b10);
        rd(32'h1008, 32'd4, 2'b00);

        // Overlapping windows: 4 cycles, reloaded 2 cycles in -> 6 continuous.
        wr(32'h1018, 32'd4, 4'hF, 2'b00);
        wr(32'h1014, 32'd1, 4'hF, 2'b00);
        hi = 0; starts = 0; rises = 0; prev = 1'b1;
        fork
            wr(32'h1014, 32'd2, 4'hF, 2'b00);
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (ctl_active) hi++;
                if (ctl_start) starts++;
                if (!prev && ctl_active) rises++;
                prev = ctl_active;
            end
        join
        chk("active_len6", hi, 6);
        chk("active_gap", rises, 0);
        chk("start_pulses2", starts, 2);
        @(posedge clk); #1;

        // Reset while a response is pending and the window is open.
        bready = 1'b0;
        wr(32'h1014, 32'd3, 4'hF, 2'b00);
        chk("pre_rst_active", {31'd0, ctl_active}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_bvalid_now", {31'd0, bvalid}, 32'd0);
        chk("rst_active_now", {31'd0, ctl_active}, 32'd0);
        chk("rst_start_now", {31'd0, ctl_start}, 32'd0);
        exp_b.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rd(32'h1018, 32'd16, 2'b00);
        rd(32'h1014, 32'd0, 2'b00);
        rd(32'h1008, 32'd0, 2'b00);

        repeat (4) @(posedge clk);
        chk("b_queue_empty", exp_b.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
